// File: rtl/grid_vga_renderer.sv
// grid_vga_renderer: 640x480@60 VGA scan-out of the 16x16 Tetris board.
// The grid is latched once per frame and drawn from 25 MHz pixel ticks.
module grid_vga_renderer #(
    parameter int          CELL_PX      = 24,
    parameter int          BOARD_X0     = 128,
    parameter int          BOARD_Y0     = 48,
    parameter int          BORDER_PX    = 4,
    parameter logic [11:0] FILL_COLOR   = 12'hF80,
    parameter logic [11:0] EMPTY_COLOR  = 12'h000,
    parameter logic [11:0] BORDER_COLOR = 12'h888,
    parameter logic [11:0] BG_COLOR     = 12'h008,
    parameter int          H_VISIBLE    = 640,
    parameter int          H_FRONT      = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BACK       = 48,
    parameter int          V_VISIBLE    = 480,
    parameter int          V_FRONT      = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BACK       = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] grid_in,
    output logic         hSync,
    output logic         vSync,
    output logic [3:0]   VGA_R,
    output logic [3:0]   VGA_G,
    output logic [3:0]   VGA_B,
    output logic         frame_start
);

    localparam int         H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int         V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int         BOARD_PX = 16 * CELL_PX;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_START  = 10'(BOARD_X0);
    localparam logic [9:0] Y_START  = 10'(BOARD_Y0);
    localparam logic [9:0] V_SNAP   = 10'(V_VISIBLE);
    localparam logic [9:0] SUB_LAST = 10'(CELL_PX - 1);

    logic [1:0]   div;
    logic         tick;
    logic [9:0]   hcount;
    logic [9:0]   vcount;
    logic [9:0]   h_next;
    logic [9:0]   v_next;
    logic         h_wrap;
    logic         v_wrap;
    logic [9:0]   hsub;
    logic [9:0]   vsub;
    logic [3:0]   hcell;
    logic [3:0]   vcell;
    logic [255:0] snap;
    logic         in_x;
    logic         in_y;
    logic         near_x;
    logic         near_y;
    logic         vis;
    logic         h_sync_on;
    logic         v_sync_on;
    logic [11:0]  color;

    assign tick   = (div == 2'd3);
    assign h_wrap = (hcount == H_LAST);
    assign v_wrap = (vcount == V_LAST);
    assign h_next = h_wrap ? 10'd0 : hcount + 10'd1;
    assign v_next = v_wrap ? 10'd0 : vcount + 10'd1;

    assign in_x   = int'(hcount) >= BOARD_X0 &&
                    int'(hcount) <  BOARD_X0 + BOARD_PX;
    assign in_y   = int'(vcount) >= BOARD_Y0 &&
                    int'(vcount) <  BOARD_Y0 + BOARD_PX;
    assign near_x = int'(hcount) >= BOARD_X0 - BORDER_PX &&
                    int'(hcount) <  BOARD_X0 + BOARD_PX + BORDER_PX;
    assign near_y = int'(vcount) >= BOARD_Y0 - BORDER_PX &&
                    int'(vcount) <  BOARD_Y0 + BOARD_PX + BORDER_PX;
    assign vis    = int'(hcount) < H_VISIBLE && int'(vcount) < V_VISIBLE;

    assign h_sync_on = int'(hcount) >= H_VISIBLE + H_FRONT &&
                       int'(hcount) <  H_VISIBLE + H_FRONT + H_SYNC;
    assign v_sync_on = int'(vcount) >= V_VISIBLE + V_FRONT &&
                       int'(vcount) <  V_VISIBLE + V_FRONT + V_SYNC;

    // Pick the colour of the pixel the counters currently point at.
    always_comb begin
        color = BG_COLOR;
        if (in_x && in_y) begin
            color = snap[{hcell, vcell}] ? FILL_COLOR : EMPTY_COLOR;
        end else if (near_x && near_y) begin
            color = BORDER_COLOR;
        end
    end

    // Pixel divider, raster counters and the per-cell sub-counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            div    <= 2'd0;
            hcount <= 10'd0;
            vcount <= 10'd0;
            hsub   <= 10'd0;
            vsub   <= 10'd0;
            hcell  <= 4'd0;
            vcell  <= 4'd0;
        end else begin
            div <= div + 2'd1;
            if (tick) begin
                hcount <= h_next;
                if (h_next == X_START) begin
                    hsub  <= 10'd0;
                    hcell <= 4'd0;
                end else if (in_x) begin
                    if (hsub == SUB_LAST) begin
                        hsub  <= 10'd0;
                        hcell <= hcell + 4'd1;
                    end else begin
                        hsub <= hsub + 10'd1;
                    end
                end
                if (h_wrap) begin
                    vcount <= v_next;
                    if (v_next == Y_START) begin
                        vsub  <= 10'd0;
                        vcell <= 4'd0;
                    end else if (in_y) begin
                        if (vsub == SUB_LAST) begin
                            vsub  <= 10'd0;
                            vcell <= vcell + 4'd1;
                        end else begin
                            vsub <= vsub + 10'd1;
                        end
                    end
                end
            end
        end
    end

    // Registered sync/RGB for the current pixel and the frame snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            hSync       <= 1'b1;
            vSync       <= 1'b1;
            VGA_R       <= 4'd0;
            VGA_G       <= 4'd0;
            VGA_B       <= 4'd0;
            frame_start <= 1'b0;
            snap        <= '0;
        end else begin
            frame_start <= 1'b0;
            if (tick) begin
                hSync <= ~h_sync_on;
                vSync <= ~v_sync_on;
                {VGA_R, VGA_G, VGA_B} <= vis ? color : 12'h000;
                if (hcount == 10'd0 && vcount == V_SNAP) begin
                    snap        <= grid_in;
                    frame_start <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_grid_vga_renderer.sv
// tb_grid_vga_renderer: small-raster instance checked every clk against
// a pixel-level model; a full-size instance checked on line timing.
module tb_grid_vga_renderer;

    localparam int C  = 2;
    localparam int X0 = 8;
    localparam int Y0 = 6;
    localparam int B  = 2;
    localparam int HV = 44;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 2;
    localparam int VV = 42;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * 4;
    localparam int SNAP_EDGE  = VV * HT * 4 + 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] grid_in = '0;
    logic [255:0] grid_zero = '0;
    logic         hs, vs, fs;
    logic [3:0]   r, g, b;
    logic         hs0, vs0, fs0;
    logic [3:0]   r0, g0, b0;

    int           checks = 0;
    int           failures = 0;
    int           e = 0;
    logic [255:0] msnap = '0;
    bit           mvalid = 1'b0;
    bit           done = 1'b0;

    always #5 clk = ~clk;

    grid_vga_renderer #(
        .CELL_PX(C), .BOARD_X0(X0), .BOARD_Y0(Y0), .BORDER_PX(B),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .grid_in(grid_in),
        .hSync(hs), .vSync(vs),
        .VGA_R(r), .VGA_G(g), .VGA_B(b),
        .frame_start(fs)
    );

    grid_vga_renderer full (
        .clk(clk), .reset(reset), .grid_in(grid_zero),
        .hSync(hs0), .vSync(vs0),
        .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
        .frame_start(fs0)
    );

    function automatic logic [11:0] pix(int h, int v, logic [255:0] s);
        if (h >= HV || v >= VV) return 12'h000;
        if (h >= X0 && h < X0 + 16*C && v >= Y0 && v < Y0 + 16*C)
            return s[((h - X0) / C) * 16 + (v - Y0) / C] ? 12'hF80 : 12'h000;
        if (h >= X0 - B && h < X0 + 16*C + B &&
            v >= Y0 - B && v < Y0 + 16*C + B)
            return 12'h888;
        return 12'h008;
    endfunction

    // Expected {rgb, hSync, vSync, frame_start} after edge e since release.
    // Pixel k is driven on edge 4k+4 (three divider clks, then the tick).
    function automatic logic [14:0] model_out();
        int k, h, v;
        if (e < 4) return {12'h000, 3'b110};
        k = e / 4 - 1;
        h = k % HT;
        v = (k / HT) % VT;
        return {pix(h, v, msnap),
                !(h >= HV + HF && h < HV + HF + HS),
                !(v >= VV + VF && v < VV + VF + VS),
                (e % 4 == 0) && (k % (HT * VT) == VV * HT)};
    endfunction

    // Edge counter and snapshot of the reference model.
    always @(posedge clk) begin
        mvalid <= 1'b1;
        if (reset) begin
            e     <= 0;
            msnap <= '0;
        end else begin
            e <= e + 1;
            if ((e + 1) % 4 == 0 &&
                ((e + 1) / 4 - 1) % (HT * VT) == VV * HT)
                msnap <= grid_in;
        end
    end

    // Every clk: DUT outputs against the model.
    always @(negedge clk) begin
        logic [14:0] want;
        if (mvalid && !done) begin
            want = model_out();
            checks++;
            if ({r, g, b, hs, vs, fs} !== want) begin
                failures++;
                $display("FAIL stream e=%0d got rgb=%h hs=%b vs=%b fs=%b want rgb=%h hs=%b vs=%b fs=%b",
                         e, {r, g, b}, hs, vs, fs,
                         want[14:3], want[2], want[1], want[0]);
            end
        end
    end

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic chk_rgb(input string name, input logic [11:0] got,
                           input logic [11:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic goto_pixel(input int h, input int v, output bit found);
        int k;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME_CLKS && !found; i++) begin
            @(negedge clk);
            k = e / 4 - 1;
            if (e >= 4 && e % 4 == 0 && k % HT == h && (k / HT) % VT == v)
                found = 1'b1;
        end
    endtask

    task automatic at_pixel(input int h, input int v,
                            input logic [11:0] want, input string name);
        bit found;
        goto_pixel(h, v, found);
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for pixel", name);
        end else begin
            chk_rgb(name, {r, g, b}, want);
        end
    endtask

    task automatic wait_fs(input string name, input int want_edge);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !seen; i++) begin
            @(negedge clk);
            if (fs === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for frame_start", name);
        end else begin
            chk_int(name, e, want_edge);
        end
    endtask

    task automatic rand_grid();
        for (int i = 0; i < 8; i++) grid_in[i*32 +: 32] = $urandom;
    endtask

    // Full-size 640x480 instance: line timing and first-line colours.
    initial begin : full_timing
        int  fall1, rise1, fall2;
        logic prev;
        fall1 = -1;
        rise1 = -1;
        fall2 = -1;
        prev  = 1'b1;
        wait (reset == 1'b0);
        for (int n = 1; n <= 5900; n++) begin
            @(negedge clk);
            if (n == 2) chk_rgb("full_rgb_before_tick", {r0, g0, b0}, 12'h000);
            if (n == 8) chk_rgb("full_rgb_visible_bg", {r0, g0, b0}, 12'h008);
            if (n == 700*4 + 4)
                chk_rgb("full_rgb_blank", {r0, g0, b0}, 12'h000);
            if (prev && !hs0) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!prev && hs0 && rise1 < 0) rise1 = n;
            prev = hs0;
        end
        chk_int("full_hsync_first_fall", fall1, 656*4 + 4);
        chk_int("full_hsync_low_clks", rise1 - fall1, 384);
        chk_int("full_line_clks", fall2 - fall1, 3200);
        chk_int("full_vsync_idle", int'(vs0), 1);
    end

    initial begin : main
        bit found;
        chk_rgb("model_pin_fill", pix(9, 7, 256'h1), 12'hF80);
        chk_rgb("model_pin_border", pix(41, 39, 256'h1), 12'h888);
        chk_rgb("model_pin_bg", pix(43, 41, 256'h1), 12'h008);

        grid_in = 256'h1;
        repeat (4) @(negedge clk);
        chk_int("reset_hsync", int'(hs), 1);
        chk_int("reset_vsync", int'(vs), 1);
        chk_rgb("reset_rgb", {r, g, b}, 12'h000);
        chk_int("reset_frame_start", int'(fs), 0);
        reset = 1'b0;

        wait_fs("first_frame_start", SNAP_EDGE);
        at_pixel(0, 0, 12'h008, "bg_origin");
        at_pixel(6, 4, 12'h888, "border_corner");
        at_pixel(8, 6, 12'hF80, "cell00_first_px");
        at_pixel(10, 6, 12'h000, "cell10_empty");
        at_pixel(9, 7, 12'hF80, "cell00_last_px");

        grid_in = '0;
        grid_in[255] = 1'b1;
        wait_fs("second_frame_start", SNAP_EDGE + FRAME_CLKS);
        at_pixel(38, 36, 12'hF80, "cell1515_first_px");
        at_pixel(37, 37, 12'h000, "left_of_cell1515");
        at_pixel(39, 37, 12'hF80, "cell1515_last_px");

        grid_in = '0;
        grid_in[16] = 1'b1;
        wait_fs("third_frame_start", SNAP_EDGE + 2*FRAME_CLKS);
        at_pixel(10, 6, 12'hF80, "cell10_fill");
        at_pixel(8, 8, 12'h000, "cell01_empty");
        goto_pixel(0, 20, found);
        grid_in = '1;
        at_pixel(8, 30, 12'h000, "old_snapshot_kept");

        wait_fs("fourth_frame_start", SNAP_EDGE + 3*FRAME_CLKS);
        at_pixel(8, 30, 12'hF80, "new_snapshot_full");
        at_pixel(39, 37, 12'hF80, "full_board_corner");

        rand_grid();
        wait_fs("fifth_frame_start", SNAP_EDGE + 4*FRAME_CLKS);
        for (int i = 0; i < 20; i++) begin
            repeat (150) @(negedge clk);
            rand_grid();
        end

        goto_pixel(30, 30, found);
        reset = 1'b1;
        @(negedge clk);
        chk_int("midreset_hsync", int'(hs), 1);
        chk_int("midreset_vsync", int'(vs), 1);
        chk_rgb("midreset_rgb", {r, g, b}, 12'h000);
        reset = 1'b0;
        at_pixel(8, 6, 12'h000, "empty_after_reset");
        wait_fs("frame_start_after_reset", SNAP_EDGE);
        repeat (HT * 4 * 10) @(negedge clk);

        done = 1'b1;
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
